// File: rtl/aqp_esp_uart_tx.sv
// ESP UART transmitter: drains a 9-bit TX FIFO and sends 8N1 frames (LSB first),
// or holds the line low for a programmable break when entry bit 8 is set.
module aqp_esp_uart_tx #(
  parameter int CLKS_PER_BIT = 25,
  parameter int BREAK_BITS   = 12
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [8:0] fifo_rddata,
  input  logic       fifo_empty,
  output logic       fifo_rd_en,
  input  logic       uart_cts_n,
  output logic       uart_txd,
  output logic       busy
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BRK_W  = (BREAK_BITS > 1) ? $clog2(BREAK_BITS) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [BAUD_W-1:0] BAUD_ZERO = BAUD_W'(0);
  localparam logic [BRK_W-1:0]  BRK_LAST  = BRK_W'(BREAK_BITS - 1);
  localparam logic [BRK_W-1:0]  BRK_ONE   = BRK_W'(1);
  localparam logic [BRK_W-1:0]  BRK_ZERO  = BRK_W'(0);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4,
    BREAK = 3'd5
  } state_t;

  state_t            state_r, state_s;
  logic [BAUD_W-1:0] baud_cnt_r, baud_cnt_s;
  logic [BRK_W-1:0]  brk_cnt_r, brk_cnt_s;
  logic [2:0]        bit_cnt_r, bit_cnt_s;
  logic [8:0]        shift_r, shift_s;
  logic [1:0]        cts_sync_r;
  logic              txd_s;
  logic              cts_ok_s;
  logic              baud_end_s;

  assign cts_ok_s   = (cts_sync_r[1] == 1'b0);
  assign baud_end_s = (baud_cnt_r == BAUD_LAST);

  // CTS synchroniser; resets to "not clear" so nothing starts before it settles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cts_sync_r <= 2'b11;
    end else begin
      cts_sync_r <= {cts_sync_r[0], uart_cts_n};
    end
  end

  // State, counters and registered outputs; outputs are derived from next state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      baud_cnt_r <= BAUD_ZERO;
      brk_cnt_r  <= BRK_ZERO;
      bit_cnt_r  <= 3'd0;
      shift_r    <= 9'd0;
      uart_txd   <= 1'b1;
      fifo_rd_en <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_r    <= state_s;
      baud_cnt_r <= baud_cnt_s;
      brk_cnt_r  <= brk_cnt_s;
      bit_cnt_r  <= bit_cnt_s;
      shift_r    <= shift_s;
      uart_txd   <= txd_s;
      fifo_rd_en <= (state_s == FETCH);
      busy       <= (state_s != IDLE);
    end
  end

  // Next-state, counter and line-level logic
  always_comb begin
    state_s    = state_r;
    baud_cnt_s = baud_cnt_r;
    brk_cnt_s  = brk_cnt_r;
    bit_cnt_s  = bit_cnt_r;
    shift_s    = shift_r;
    txd_s      = 1'b1;
    case (state_r)
      IDLE: begin
        baud_cnt_s = BAUD_ZERO;
        if (!fifo_empty && cts_ok_s) begin
          state_s = FETCH;
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: begin
        shift_s    = fifo_rddata;
        baud_cnt_s = BAUD_ZERO;
        if (fifo_rddata[8]) begin
          state_s = BREAK;
        end else begin
          state_s = START;
        end
      end
      START: begin
        if (baud_end_s) begin
          baud_cnt_s = BAUD_ZERO;
          bit_cnt_s  = 3'd0;
          state_s    = DATA;
        end else begin
          baud_cnt_s = baud_cnt_r + BAUD_ONE;
        end
      end
      DATA: begin
        if (baud_end_s) begin
          baud_cnt_s = BAUD_ZERO;
          shift_s    = {1'b0, shift_r[8:1]};
          bit_cnt_s  = bit_cnt_r + 3'd1;
          if (bit_cnt_r == 3'd7) begin
            state_s = STOP;
          end else begin
            state_s = DATA;
          end
        end else begin
          baud_cnt_s = baud_cnt_r + BAUD_ONE;
        end
      end
      STOP: begin
        if (baud_end_s) begin
          baud_cnt_s = BAUD_ZERO;
          state_s    = IDLE;
        end else begin
          baud_cnt_s = baud_cnt_r + BAUD_ONE;
        end
      end
      BREAK: begin
        if (baud_end_s) begin
          baud_cnt_s = BAUD_ZERO;
          if (brk_cnt_r == BRK_LAST) begin
            brk_cnt_s = BRK_ZERO;
            state_s   = STOP;
          end else begin
            brk_cnt_s = brk_cnt_r + BRK_ONE;
          end
        end else begin
          baud_cnt_s = baud_cnt_r + BAUD_ONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    // The line level follows the state being entered so uart_txd stays a clean flop output
    case (state_s)
      START:   txd_s = 1'b0;
      BREAK:   txd_s = 1'b0;
      DATA:    txd_s = shift_s[0];
      default: txd_s = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_aqp_esp_uart_tx.sv
// Scoreboard bench for aqp_esp_uart_tx: stimulus queues hand-computed frames,
// a monitor decodes uart_txd sample by sample and compares against the queue.
module tb_aqp_esp_uart_tx;

  localparam int CPB = 4;
  localparam int BB  = 12;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [8:0] fifo_rddata;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic       uart_cts_n;
  logic       uart_txd;
  logic       busy;

  logic       wr_en;
  logic [8:0] wr_data;
  logic [8:0] mem [0:15];
  logic [4:0] wr_ptr = 5'd0;
  logic [4:0] rd_ptr = 5'd0;

  int cyc = 0;
  int rd_cnt = 0;
  logic rd_empty_seen = 1'b0;
  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic       brk;
    logic [9:0] frame;
    int         exp_start;
  } exp_t;
  exp_t exp_q[$];
  logic mon_en = 1'b0;
  logic collecting = 1'b0;

  aqp_esp_uart_tx #(.CLKS_PER_BIT(CPB), .BREAK_BITS(BB)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .fifo_rddata(fifo_rddata),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .uart_cts_n (uart_cts_n),
    .uart_txd   (uart_txd),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Cycle counter: equals T just after active edge T
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural TX FIFO with registered head
  always @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[3:0]] <= wr_data;
      wr_ptr <= wr_ptr + 5'd1;
    end
    if (fifo_rd_en && !fifo_empty) rd_ptr <= rd_ptr + 5'd1;
  end
  assign fifo_empty  = (wr_ptr == rd_ptr);
  assign fifo_rddata = mem[rd_ptr[3:0]];

  // Pop strobe bookkeeping
  always @(posedge clk) begin
    if (fifo_rd_en) rd_cnt <= rd_cnt + 1;
    if (fifo_rd_en && fifo_empty) rd_empty_seen <= 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [8:0] d, output int t);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    t = cyc;
  endtask

  task automatic push(input logic brk, input logic [9:0] frame, input int start);
    exp_t e;
    e.brk = brk;
    e.frame = frame;
    e.exp_start = start;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || collecting) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain_timeout"}, (n >= 1000), 1'b0);
    repeat (3) @(negedge clk);
    check({name, "_idle_txd"}, uart_txd, 1'b1);
    check({name, "_idle_busy"}, busy, 1'b0);
  endtask

  // Monitor: decode every frame on uart_txd and compare with the scoreboard
  initial begin : monitor
    exp_t e;
    int   bad_k;
    int   start;
    int   nsamp;
    int   idx;
    logic expb;
    logic gotb;
    idx = 0;
    forever begin
      @(negedge clk);
      if (mon_en && reset_n && uart_txd == 1'b0) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_frame: txd fell at cycle %0d, nothing expected", cyc);
          for (int w = 0; w < 100 && uart_txd == 1'b0; w++) @(negedge clk);
        end else begin
          e = exp_q.pop_front();
          collecting = 1'b1;
          start = cyc;
          bad_k = -1;
          expb = 1'b0;
          gotb = 1'b0;
          nsamp = e.brk ? (BB + 1) * CPB : 10 * CPB;
          for (int k = 0; k < nsamp; k++) begin
            logic eb;
            if (k > 0) @(negedge clk);
            eb = e.brk ? (k >= BB * CPB) : e.frame[k / CPB];
            if (uart_txd !== eb && bad_k < 0) begin
              bad_k = k;
              expb = eb;
              gotb = uart_txd;
            end
          end
          vectors++;
          if (bad_k >= 0) begin
            miscompares++;
            $display("FAIL frame%0d_bits: txd=%b at sample %0d, expected %b", idx, gotb, bad_k, expb);
          end
          if (e.exp_start >= 0) check($sformatf("frame%0d_start_cycle", idx), start, e.exp_start);
          idx++;
          collecting = 1'b0;
        end
      end
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // Directed stimulus
  initial begin
    int   t;
    int   t2;
    int   d;
    int   r0;
    logic bad_rd;
    logic bad_txd;
    logic bad_busy;
    logic any_low;
    reset_n    = 1'b0;
    uart_cts_n = 1'b0;
    wr_en      = 1'b0;
    wr_data    = 9'd0;
    repeat (3) @(negedge clk);
    check("reset_txd", uart_txd, 1'b1);
    check("reset_rd_en", fifo_rd_en, 1'b0);
    check("reset_busy", busy, 1'b0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Asynchronous reset in the middle of DATA
    wr(9'h0F0, t);
    while (cyc < t + 10) @(negedge clk);
    check("busy_mid_data", busy, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_txd", uart_txd, 1'b1);
    check("async_reset_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bad_rd = 1'b0;
    bad_txd = 1'b0;
    bad_busy = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (fifo_rd_en !== 1'b0) bad_rd = 1'b1;
      if (uart_txd !== 1'b1) bad_txd = 1'b1;
      if (busy !== 1'b0) bad_busy = 1'b1;
    end
    check("post_reset_rd_en", bad_rd, 1'b0);
    check("post_reset_txd", bad_txd, 1'b0);
    check("post_reset_busy", bad_busy, 1'b0);
    check("post_reset_pops", rd_cnt, 1);
    mon_en = 1'b1;

    // Single byte 0xA5: 0,1,0,1,0,0,1,0,1,1
    r0 = rd_cnt;
    wr(9'h0A5, t);
    push(1'b0, 10'b1101001010, t + 2);
    drain("single");
    check("single_pops", rd_cnt, r0 + 1);

    // Three back-to-back bytes, 42-cycle start spacing
    r0 = rd_cnt;
    wr(9'h055, t);
    push(1'b0, 10'b1010101010, t + 2);
    wr(9'h0FF, t2);
    push(1'b0, 10'b1111111110, t + 44);
    wr(9'h000, t2);
    push(1'b0, 10'b1000000000, t + 86);
    drain("triple");
    check("triple_pops", rd_cnt, r0 + 3);

    // Breaks: 48 low + 4 high; low byte ignored
    r0 = rd_cnt;
    wr(9'h100, t);
    push(1'b1, 10'b0000000000, t + 2);
    drain("break0");
    wr(9'h1C3, t);
    push(1'b1, 10'b0000000000, t + 2);
    drain("break1");
    check("break_pops", rd_cnt, r0 + 2);

    // CTS deasserted: entry waits, then starts 4 cycles after CTS drops
    @(negedge clk);
    uart_cts_n = 1'b1;
    repeat (4) @(negedge clk);
    r0 = rd_cnt;
    wr(9'h00F, t);
    any_low = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (uart_txd !== 1'b1) any_low = 1'b1;
    end
    check("cts_hold_pops", rd_cnt, r0);
    check("cts_hold_txd_low", any_low, 1'b0);
    d = cyc;
    uart_cts_n = 1'b0;
    push(1'b0, 10'b1000011110, d + 4);
    drain("cts_release");
    check("cts_release_pops", rd_cnt, r0 + 1);

    // CTS raised during DATA of 0x3C: frame completes, 0x81 held back
    r0 = rd_cnt;
    wr(9'h03C, t);
    push(1'b0, 10'b1001111000, t + 2);
    wr(9'h081, t2);
    while (cyc < t + 14) @(negedge clk);
    uart_cts_n = 1'b1;
    while (cyc < t + 80) @(negedge clk);
    check("midframe_pops", rd_cnt, r0 + 1);
    check("midframe_queue", exp_q.size(), 0);
    check("midframe_hold_busy", busy, 1'b0);
    d = cyc;
    uart_cts_n = 1'b0;
    push(1'b0, 10'b1100000010, d + 4);
    drain("midframe_next");
    check("midframe_total_pops", rd_cnt, r0 + 2);
    check("rd_en_while_empty", rd_empty_seen, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
